// File: rtl/decode_sequencer.sv
// decode_sequencer: tracks the requested setting word and runs one load/wait/latch
// cycle of the mod-80/mod-81 divider pair per change. The residues are then presented
// to the PWM generators.
// Optional build macro DECODE_TIMEOUT_EN adds a WAIT watchdog with a sticky error
// flag and an automatic retry.
module decode_sequencer #(
  parameter int unsigned WIDTH_W        = 13,
  parameter int unsigned WIDTH_R        = 7,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH_W-1:0] w_in,
  output logic               div_load,
  output logic [WIDTH_W-1:0] div_w,
  input  logic [WIDTH_R-1:0] div_r_a,
  input  logic [WIDTH_R-1:0] div_r_b,
  input  logic               div_done_a,
  input  logic               div_done_b,
  output logic [WIDTH_R-1:0] a_out,
  output logic [WIDTH_R-1:0] b_out,
  output logic               pwm_en,
  output logic               busy,
  output logic               error
);

  // The blanking cycle plus at least one real WAIT cycle must fit in the timeout.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StRun} state_e;

  state_e               state_q, state_d;
  logic [WIDTH_W-1:0]   div_w_q, div_w_d;
  logic [WIDTH_R-1:0]   a_q, a_d, b_q, b_d;
  logic                 first_q, first_d;  // forces one conversion after reset
  logic                 blank_q, blank_d;  // high during the first WAIT cycle
  logic                 w_changed;
  logic                 both_done;

`ifdef DECODE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  assign w_changed = (w_in != div_w_q);
  assign both_done = div_done_a & div_done_b;

  // Next-state logic: change capture, load sequencing and residue latching.
  always_comb begin
    state_d = state_q;
    div_w_d = div_w_q;
    a_d     = a_q;
    b_d     = b_q;
    first_d = first_q;
    blank_d = 1'b0;
`ifdef DECODE_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (first_q || w_changed) begin
          div_w_d = w_in;
          first_d = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = StWait;
        blank_d = 1'b1;
`ifdef DECODE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // Dones seen in the blanking cycle may be left over from the previous operation.
        if (!blank_q && both_done) begin
          a_d = div_r_a;
          b_d = div_r_b;
          if (w_changed) begin
            div_w_d = w_in;
            state_d = StLoad;
          end else begin
            state_d = StRun;
          end
        end
`ifdef DECODE_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StRun: begin
        if (w_changed) begin
          div_w_d = w_in;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      div_w_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      first_q <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_w_q <= div_w_d;
      a_q     <= a_d;
      b_q     <= b_d;
      first_q <= first_d;
      blank_q <= blank_d;
    end
  end

`ifdef DECODE_TIMEOUT_EN
  // WAIT-cycle watchdog and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // Outputs decode directly from registered state, so reset cuts them off at once.
  assign div_load = (state_q == StLoad);
  assign busy     = (state_q == StLoad) || (state_q == StWait);
  assign pwm_en   = (state_q == StRun);
  assign div_w    = div_w_q;
  assign a_out    = a_q;
  assign b_out    = b_q;

endmodule
